// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the instruction fetch unit
//
// Contents:
//   fetch_state_t     FSM encoding: ST_REQ (request outstanding), ST_HOLD (instruction presented)
//   INSTR_W           instruction word width
//   DEFAULT_RESET_PC  default first fetch address after reset
package instr_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC owner, imem req/ack, valid/ready to decode
//
// Ports:
//   clk_i          in   clock, rising edge
//   rst_i          in   synchronous active-high reset
//   imem_req_o     out  fetch request, held with stable imem_addr_o until imem_ack_i
//   imem_addr_o    out  word-aligned byte address of the outstanding request
//   imem_ack_i     in   memory completes the request this cycle
//   imem_rdata_i   in   instruction word, valid with imem_ack_i
//   redirect_i     in   restart fetch at redirect_pc_i
//   redirect_pc_i  in   redirect target (low two bits dropped)
//   instr_valid_o  out  instr_o/pc_o hold a valid instruction
//   instr_ready_i  in   decode accepts when instr_valid_o & instr_ready_i
//   instr_o        out  instruction word to decode
//   pc_o           out  PC of instr_o
//   align_err_o    out  one-cycle pulse after a misaligned redirect target
//   fetch_cnt_o    out  instructions accepted by decode, wrapping
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                imem_req_o,
  output logic [ADDR_W-1:0]   imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [INSTR_W-1:0]  imem_rdata_i,
  input  logic                redirect_i,
  input  logic [ADDR_W-1:0]   redirect_pc_i,
  output logic                instr_valid_o,
  input  logic                instr_ready_i,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [ADDR_W-1:0]   pc_o,
  output logic                align_err_o,
  output logic [31:0]         fetch_cnt_o
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  // addr_q is the address of the outstanding request; it differs from pc_q
  // only while a redirect arrives before the in-flight request is acked.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              kill_q, kill_d;
  logic              capture;
  logic              accept;
  logic [ADDR_W-1:0] redirect_tgt;

  assign redirect_tgt  = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign imem_req_o    = (state_q == ST_REQ) && !rst_i;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = (state_q == ST_HOLD);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    kill_d  = kill_q;
    capture = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (imem_ack_i) begin
          if (redirect_i) begin
            // Data for the old stream is dropped; restart at the target.
            pc_d   = redirect_tgt;
            kill_d = 1'b0;
          end else if (kill_q) begin
            kill_d = 1'b0;
          end else begin
            capture = 1'b1;
            pc_d    = pc_q + ADDR_W'(4);
            state_d = ST_HOLD;
          end
          addr_d = pc_d;
        end else if (redirect_i) begin
          // Never abandon an issued request: keep addr_q, mark its data dead.
          pc_d   = redirect_tgt;
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        accept = instr_ready_i;
        if (redirect_i) begin
          pc_d    = redirect_tgt;
          state_d = ST_REQ;
        end else if (instr_ready_i) begin
          state_d = ST_REQ;
        end
        addr_d = pc_d;
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      kill_q      <= 1'b0;
      instr_o     <= '0;
      pc_o        <= '0;
      align_err_o <= 1'b0;
      fetch_cnt_o <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      kill_q      <= kill_d;
      align_err_o <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
      if (capture) begin
        instr_o <= imem_rdata_i;
        pc_o    <= pc_q;
      end
      if (accept) begin
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        align_err;
  logic [31:0] fetch_cnt;

  int checks   = 0;
  int failures = 0;

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .pc_o          (pc),
    .align_err_o   (align_err),
    .fetch_cnt_o   (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    tick();
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr,                32'd0);
    chk("rst_pc",    pc,                   32'd0);
    chk("rst_align", {31'd0, align_err},   32'd0);
    chk("rst_cnt",   fetch_cnt,            32'd0);
    rst = 1'b0;
    #1;
    chk("rel_req",  {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr,         32'h0);

    // 1: zero-wait memory, decode always ready
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      imem_ack = 1'b1; imem_rdata = 32'h1000_0000 + 32'(4 * k);
      tick();
      imem_ack = 1'b0;
      chk("t1_valid", {31'd0, instr_valid}, 32'd1);
      chk("t1_pc",    pc,    32'(4 * k));
      chk("t1_instr", instr, 32'h1000_0000 + 32'(4 * k));
      chk("t1_req_lo", {31'd0, imem_req}, 32'd0);
      tick();
      chk("t1_valid_lo", {31'd0, instr_valid}, 32'd0);
      chk("t1_cnt",  fetch_cnt, 32'(k + 1));
      chk("t1_addr", imem_addr, 32'(4 * k + 4));
    end

    // 2: slow memory, decode stalls 5 cycles
    instr_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t2_req",  {31'd0, imem_req}, 32'd1);
      chk("t2_addr", imem_addr, 32'h10);
    end
    imem_ack = 1'b1; imem_rdata = 32'h2000_0010;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      chk("t2_valid", {31'd0, instr_valid}, 32'd1);
      chk("t2_instr", instr, 32'h2000_0010);
      chk("t2_pc",    pc, 32'h10);
      chk("t2_cnt",   fetch_cnt, 32'd4);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    chk("t2_cnt_acc", fetch_cnt, 32'd5);
    chk("t2_addr2",   imem_addr, 32'h14);

    // 3: back-to-back redirects while request at 0x14 is pending
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("t3_req",   {31'd0, imem_req}, 32'd1);
    chk("t3_addr",  imem_addr, 32'h14);
    chk("t3_align", {31'd0, align_err}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0014;
    tick();
    chk("t3_drop_valid", {31'd0, instr_valid}, 32'd0);
    chk("t3_new_addr",   imem_addr, 32'h100);
    imem_rdata = 32'h3000_0100;
    tick();
    imem_ack = 1'b0;
    chk("t3_valid", {31'd0, instr_valid}, 32'd1);
    chk("t3_pc",    pc,    32'h100);
    chk("t3_instr", instr, 32'h3000_0100);

    // 4: redirect in HOLD with ready in the same cycle
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("t4_cnt",   fetch_cnt, 32'd6);
    chk("t4_valid", {31'd0, instr_valid}, 32'd0);
    chk("t4_addr",  imem_addr, 32'h40);
    imem_ack = 1'b1; imem_rdata = 32'h4000_0040;
    tick();
    imem_ack = 1'b0;
    chk("t4_pc", pc, 32'h40);
    tick();
    chk("t4_cnt2", fetch_cnt, 32'd7);

    // 5: misaligned redirect while request at 0x44 is pending
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    chk("t5_align_hi", {31'd0, align_err}, 32'd1);
    chk("t5_addr",     imem_addr, 32'h44);
    tick();
    chk("t5_align_lo", {31'd0, align_err}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0044;
    tick();
    chk("t5_new_addr", imem_addr, 32'h100);
    imem_rdata = 32'h5000_0100;
    tick();
    imem_ack = 1'b0;
    chk("t5_pc",    pc,    32'h100);
    chk("t5_instr", instr, 32'h5000_0100);
    tick();
    chk("t5_cnt", fetch_cnt, 32'd8);

    // 6: reset with a request pending
    chk("t6_pend", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_req",   {31'd0, imem_req},    32'd0);
    chk("t6_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_cnt",   fetch_cnt, 32'd0);
    rst = 1'b0;
    #1;
    chk("t6_req_rel", {31'd0, imem_req}, 32'd1);
    chk("t6_addr",    imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h6000_0000;
    tick();
    imem_ack = 1'b0;
    chk("t6_valid2", {31'd0, instr_valid}, 32'd1);
    chk("t6_instr",  instr, 32'h6000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
